scoot_bot_hold: RTL and testbench

Parametrised successor to the four-direction scoot bot. It maps a vector of light-sensor inputs to motor-enable outputs. Each channel has a programmable persistence counter that keeps its motor driven for a set number of cycles after its light drops. A selectable drive mode provides plain persistence, single-motor exclusive drive with round-robin hand-over, or cancellation of opposing directions. It sits between the sensor sampling logic and the motor drivers of a bot.

---
 rtl/scoot_bot_pkg.sv | 14 +
 rtl/scoot_hold_chan.sv | 20 ++
 rtl/scoot_bot_hold.sv | 84 ++++++++
 tb/tb_scoot_bot_hold.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/scoot_bot_pkg.sv
// scoot_bot_pkg: shared mode codes, exclusive-FSM state type and opposite-channel helper.
package scoot_bot_pkg;
    localparam logic [1:0] MODE_PERSIST = 2'd0;
    localparam logic [1:0] MODE_EXCL    = 2'd1;
    localparam logic [1:0] MODE_CANCEL  = 2'd2;

    typedef logic [0:0] excl_st_t;
    localparam excl_st_t ST_IDLE  = 1'b0;
    localparam excl_st_t ST_DRIVE = 1'b1;

    function automatic int opp(input int i, input int dirs);
        return (i + dirs / 2) % dirs;
    endfunction
endpackage

// File: rtl/scoot_hold_chan.sv
// scoot_hold_chan: one channel's persistence counter; req stays high while lit or counting down.
module scoot_hold_chan #(
    parameter int HOLD_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_light,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    output logic              o_req
);
    logic [HOLD_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_light) r_cnt <= i_hold_cycles;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end

    assign o_req = i_light | (r_cnt != '0);
endmodule

// File: rtl/scoot_bot_hold.sv
// scoot_bot_hold: light sensors to motor enables with per-channel persistence and
// persist / exclusive round-robin / opposing-cancel drive modes.
module scoot_bot_hold
    import scoot_bot_pkg::*;
#(
    parameter int DIRS   = 4,
    parameter int HOLD_W = 4,
    parameter int IDX_W  = $clog2(DIRS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DIRS-1:0]   i_light,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    input  logic [1:0]        i_mode,
    output logic [DIRS-1:0]   o_motor,
    output logic              o_owner_valid,
    output logic [IDX_W-1:0]  o_owner
);
    logic [DIRS-1:0]  w_req;
    logic [DIRS-1:0]  w_cancel;
    logic [DIRS-1:0]  w_excl_motor;
    logic [DIRS-1:0]  w_motor;
    logic [IDX_W:0]   w_scan_ptr;
    logic [IDX_W:0]   w_scan_nxt;
    logic [IDX_W:0]   w_gnt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_keep;
    logic             w_drop;
    logic [IDX_W-1:0] r_ptr;
    excl_st_t         r_state;

    // Returns {found, index} of the first requester at or after start, with wrap.
    function automatic logic [IDX_W:0] scan(input logic [DIRS-1:0] req, input int start);
        logic [IDX_W:0] res;
        res = '0;
        for (int k = DIRS - 1; k >= 0; k--)
            if (req[(start + k) % DIRS]) res = {1'b1, IDX_W'((start + k) % DIRS)};
        return res;
    endfunction

    for (genvar i = 0; i < DIRS; i++) begin : g_ch
        scoot_hold_chan #(.HOLD_W(HOLD_W)) u_chan (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_light      (i_light[i]),
            .i_hold_cycles(i_hold_cycles),
            .o_req        (w_req[i])
        );
        assign w_cancel[i] = w_req[i] & ~w_req[opp(i, DIRS)];
    end

    always_comb begin
        w_scan_ptr   = scan(w_req, int'(r_ptr));
        w_scan_nxt   = scan(w_req, int'(o_owner) + 1);
        w_keep       = (r_state == ST_DRIVE) && w_req[o_owner];
        w_drop       = (r_state == ST_DRIVE) && !w_req[o_owner];
        w_gnt        = w_keep ? {1'b1, o_owner} : w_drop ? w_scan_nxt : w_scan_ptr;
        w_ptr_nxt    = w_drop ? IDX_W'((int'(o_owner) + 1) % DIRS) : r_ptr;
        w_excl_motor = w_gnt[IDX_W] ? DIRS'(1) << w_gnt[IDX_W-1:0] : '0;
        w_motor      = (i_mode == MODE_CANCEL) ? w_cancel :
                       (i_mode == MODE_EXCL)   ? w_excl_motor : w_req;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_motor       <= '0;
            o_owner_valid <= 1'b0;
            o_owner       <= '0;
            r_ptr         <= '0;
            r_state       <= ST_IDLE;
        end else begin
            o_motor <= w_motor;
            if (i_mode == MODE_EXCL) begin
                r_state       <= w_gnt[IDX_W] ? ST_DRIVE : ST_IDLE;
                o_owner_valid <= w_gnt[IDX_W];
                r_ptr         <= w_ptr_nxt;
                if (w_gnt[IDX_W]) o_owner <= w_gnt[IDX_W-1:0];
            end else begin
                r_state       <= ST_IDLE;
                o_owner_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_scoot_bot_hold.sv
// tb_scoot_bot_hold: directed vectors with hand-computed expectations for scoot_bot_hold.
module tb_scoot_bot_hold;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] light = '0;
    logic [3:0] hold = '0;
    logic [1:0] mode = 2'd0;
    logic [3:0] motor;
    logic       owner_valid;
    logic [1:0] owner;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_hi;

    scoot_bot_hold #(.DIRS(4), .HOLD_W(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_light      (light),
        .i_hold_cycles(hold),
        .i_mode       (mode),
        .o_motor      (motor),
        .o_owner_valid(owner_valid),
        .o_owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic chk_excl(input string tag, input logic [3:0] m, input logic v, input logic [1:0] o);
        chk({tag, "_motor"}, 8'(motor), 8'(m));
        chk({tag, "_valid"}, 8'(owner_valid), 8'(v));
        if (v) chk({tag, "_owner"}, 8'(owner), 8'(o));
    endtask

    initial begin
        light = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_motor", 8'(motor), 8'h0);
            chk("rst_valid", 8'(owner_valid), 8'h0);
        end
        rst_n = 1'b1;
        tick();
        chk("rst_release", 8'(motor), 8'hf);
        light = 4'b0000;
        tick();
        chk("h0_drop", 8'(motor), 8'h0);

        hold = 4'd3;
        light = 4'b0100;
        tick();
        chk("pulse_e0", 8'(motor), 8'h4);
        light = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("pulse_hold", 8'(motor), 8'h4);
        end
        tick();
        chk("pulse_end", 8'(motor), 8'h0);

        light = 4'b0100;
        tick();
        light = 4'b0000;
        tick();
        light = 4'b0100;
        tick();
        light = 4'b0000;
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk("retrig_hold", 8'(motor), 8'h4);
        end
        tick();
        chk("retrig_end", 8'(motor), 8'h0);

        light = 4'b0010;
        tick();
        chk("midhold_on", 8'(motor), 8'h2);
        light = 4'b0000;
        rst_n = 1'b0;
        tick();
        chk("midhold_rst", 8'(motor), 8'h0);
        rst_n = 1'b1;
        tick();
        chk("midhold_clr", 8'(motor), 8'h0);

        hold = 4'd15;
        light = 4'b0001;
        tick();
        light = 4'b0000;
        hold = 4'd2;
        n_hi = (motor[0] === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (motor[0] === 1'b1) n_hi++;
        end
        chk("max_hold_len", 8'(n_hi), 8'd16);

        hold = 4'd0;
        mode = 2'd2;
        light = 4'b0101;
        tick();
        chk("cancel_0101", 8'(motor), 8'h0);
        light = 4'b0011;
        tick();
        chk("cancel_0011", 8'(motor), 8'h3);
        light = 4'b1000;
        tick();
        chk("cancel_1000", 8'(motor), 8'h8);

        mode = 2'd1;
        light = 4'b0110;
        tick();
        chk_excl("ex_grant", 4'b0010, 1'b1, 2'd1);
        light = 4'b0100;
        tick();
        chk_excl("ex_handover", 4'b0100, 1'b1, 2'd2);
        light = 4'b0000;
        tick();
        chk_excl("ex_idle", 4'b0000, 1'b0, 2'd0);
        light = 4'b1001;
        tick();
        chk_excl("ex_ptr3", 4'b1000, 1'b1, 2'd3);
        light = 4'b0001;
        tick();
        chk_excl("ex_wrap", 4'b0001, 1'b1, 2'd0);
        light = 4'b1001;
        tick();
        chk_excl("ex_nopreempt", 4'b0001, 1'b1, 2'd0);
        light = 4'b0101;
        tick();
        chk_excl("ex_nopreempt2", 4'b0001, 1'b1, 2'd0);
        light = 4'b0100;
        tick();
        chk_excl("ex_to2", 4'b0100, 1'b1, 2'd2);
        light = 4'b1100;
        tick();
        chk_excl("ex_hold2", 4'b0100, 1'b1, 2'd2);
        mode = 2'd0;
        tick();
        chk_excl("sw_persist", 4'b1100, 1'b0, 2'd0);
        mode = 2'd1;
        tick();
        chk_excl("ex_ptr_kept", 4'b0100, 1'b1, 2'd2);
        mode = 2'd3;
        light = 4'b0011;
        tick();
        chk_excl("mode3", 4'b0011, 1'b0, 2'd0);

        mode = 2'd1;
        light = 4'b0010;
        tick();
        chk_excl("ex_pre_rst", 4'b0010, 1'b1, 2'd1);
        rst_n = 1'b0;
        tick();
        chk_excl("ex_rst", 4'b0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        light = 4'b1010;
        tick();
        chk_excl("ex_rst_ptr0", 4'b0010, 1'b1, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
